// File: rtl/fsm_rx.sv
// 8N1 UART receiver: oversampled start/data/stop FSM with a single-entry output register
// and frame-error and overrun reporting.
module fsm_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       Bclk,
    input  logic       reset_n,
    input  logic       rx_in,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun_err
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] HALF_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t          state;
    logic            sync1;
    logic            s;
    logic            s_prev;
    logic [TW-1:0]   tick;
    logic [2:0]      bit_count;
    logic [7:0]      shift_reg;
    logic            stop_hold;
    logic            deliver;

    assign rx_busy = (state != IDLE);

    always_ff @(posedge Bclk) begin
        // NOTE: the synchronizer resets to 0 so a line that is low out of reset never looks like a start bit.
        if (!reset_n) begin
            sync1       <= 1'b0;
            s           <= 1'b0;
            s_prev      <= 1'b0;
            state       <= IDLE;
            tick        <= '0;
            bit_count   <= '0;
            shift_reg   <= '0;
            stop_hold   <= 1'b0;
            deliver     <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            // NOTE: every register here uses <= so all reads see the pre-edge values.
            sync1       <= rx_in;
            s           <= sync1;
            s_prev      <= s;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            deliver     <= 1'b0;

            // A delivery wins over an acknowledge arriving in the same cycle.
            if (deliver) begin
                rx_data     <= shift_reg;
                rx_valid    <= 1'b1;
                overrun_err <= rx_valid && !rx_ack;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (s_prev && !s) begin
                        state <= START;
                        tick  <= '0;
                    end
                end
                START: begin
                    if (tick == HALF_M1) begin
                        tick <= '0;
                        if (!s) begin
                            state     <= DATA;
                            bit_count <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                DATA: begin
                    if (tick == FULL_M1) begin
                        tick      <= '0;
                        shift_reg <= {s, shift_reg[7:1]};
                        if (bit_count == 3'd7) state <= STOP;
                        else                   bit_count <= bit_count + 3'd1;
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                STOP: begin
                    // After a bad stop bit, wait with the counter frozen for the line to recover.
                    if (stop_hold) begin
                        if (s) begin
                            stop_hold <= 1'b0;
                            state     <= IDLE;
                        end
                    end else if (tick == FULL_M1) begin
                        tick <= '0;
                        if (s) begin
                            deliver <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            stop_hold <= 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_rx.sv
// Directed bench for fsm_rx at OVERSAMPLE=16: reception latency, glitch rejection,
// framing error, overrun, same-cycle acknowledge and mid-frame reset.
module tb_fsm_rx;

    logic       Bclk = 1'b0;
    logic       reset_n;
    logic       rx_in;
    logic       rx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;

    int n_tests = 0;
    int n_fail  = 0;

    fsm_rx #(.OVERSAMPLE(16)) dut (
        .Bclk        (Bclk),
        .reset_n     (reset_n),
        .rx_in       (rx_in),
        .rx_ack      (rx_ack),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    always #5 Bclk = ~Bclk;

    // Event monitor: edge timestamps and pulse counts, sampled mid-cycle.
    int   cyc = 0;
    logic busy_q = 1'b0;
    logic valid_q = 1'b0;
    int   busy_rise_cyc = 0;
    int   busy_fall_cyc = 0;
    int   valid_rise_cyc = 0;
    int   busy_rises = 0;
    int   fe_cnt = 0;
    int   ov_cnt = 0;

    always @(posedge Bclk) cyc <= cyc + 1;

    always @(negedge Bclk) begin
        if (rx_busy === 1'b1 && busy_q !== 1'b1) begin
            busy_rise_cyc = cyc;
            busy_rises    = busy_rises + 1;
        end
        if (rx_busy === 1'b0 && busy_q === 1'b1) busy_fall_cyc = cyc;
        if (rx_valid === 1'b1 && valid_q !== 1'b1) valid_rise_cyc = cyc;
        if (frame_err === 1'b1) fe_cnt = fe_cnt + 1;
        if (overrun_err === 1'b1) ov_cnt = ov_cnt + 1;
        busy_q  = rx_busy;
        valid_q = rx_valid;
    end

    task automatic drive_bit(input logic b, input int n);
        rx_in = b;
        repeat (n) @(negedge Bclk);
    endtask

    // Stop bit held for stop_len cycles; optionally pulse rx_ack on the delivery cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input int stop_len,
                              input bit ack_on_delivery);
        drive_bit(1'b0, 16);
        for (int i = 0; i < 8; i++) drive_bit(d[i], 16);
        if (ack_on_delivery) begin
            rx_in = stop_lvl;
            repeat (11) @(negedge Bclk);
            rx_ack = 1'b1;
            @(negedge Bclk);
            rx_ack = 1'b0;
            repeat (stop_len - 12) @(negedge Bclk);
        end else begin
            drive_bit(stop_lvl, stop_len);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        rx_in   = 1'b1;
        rx_ack  = 1'b0;
        repeat (3) @(negedge Bclk);
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rx_data); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_tests++; if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun_err); end
        reset_n = 1'b1;
        repeat (10) @(negedge Bclk);
        n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b expected 0", rx_busy); end
    endtask

    task automatic test_receive_a5;
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1, 16, 1'b0);
        drive_bit(1'b1, 20);
        n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL a5_data: got %h expected a5", rx_data); end
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL a5_valid: got %b expected 1", rx_valid); end
        n_tests++; if (valid_rise_cyc - busy_rise_cyc !== 153) begin n_fail++; $display("FAIL a5_latency: got %0d expected 153", valid_rise_cyc - busy_rise_cyc); end
        n_tests++; if (busy_fall_cyc - busy_rise_cyc !== 152) begin n_fail++; $display("FAIL a5_busy_len: got %0d expected 152", busy_fall_cyc - busy_rise_cyc); end
        n_tests++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL a5_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_glitch;
        int fe0;
        rx_ack = 1'b1;
        @(negedge Bclk);
        rx_ack = 1'b0;
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ack_clear: got %b expected 0", rx_valid); end
        fe0 = fe_cnt;
        drive_bit(1'b0, 5);
        drive_bit(1'b1, 30);
        n_tests++; if (busy_fall_cyc - busy_rise_cyc !== 8) begin n_fail++; $display("FAIL glitch_start_len: got %0d expected 8", busy_fall_cyc - busy_rise_cyc); end
        n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", rx_busy); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
        n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL glitch_data: got %h expected a5", rx_data); end
        n_tests++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    endtask

    task automatic test_frame_error;
        int fe0;
        fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0, 320, 1'b0);
        n_tests++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL fe_hold_busy: got %b expected 1", rx_busy); end
        drive_bit(1'b1, 20);
        n_tests++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL fe_pulses: got %0d expected 1", fe_cnt - fe0); end
        n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL fe_release_busy: got %b expected 0", rx_busy); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL fe_valid: got %b expected 0", rx_valid); end
        n_tests++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL fe_data: got %h expected a5", rx_data); end
    endtask

    task automatic test_overrun;
        int ov0;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, 16, 1'b0);
        drive_bit(1'b1, 20);
        send_frame(8'h22, 1'b1, 16, 1'b0);
        drive_bit(1'b1, 20);
        n_tests++; if (ov_cnt - ov0 !== 1) begin n_fail++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt - ov0); end
        n_tests++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL ovr_data: got %h expected 22", rx_data); end
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid: got %b expected 1", rx_valid); end
        rx_ack = 1'b1;
        @(negedge Bclk);
        rx_ack = 1'b0;
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_ack_clear: got %b expected 0", rx_valid); end
        rx_ack = 1'b1;
        @(negedge Bclk);
        rx_ack = 1'b0;
        repeat (2) @(negedge Bclk);
        n_tests++; if (rx_valid !== 1'b0 || rx_data !== 8'h22) begin n_fail++; $display("FAIL idle_ack: got valid %b data %h expected 0 22", rx_valid, rx_data); end
    endtask

    task automatic test_back_to_back;
        int ov0;
        send_frame(8'h11, 1'b1, 16, 1'b0);
        drive_bit(1'b1, 20);
        n_tests++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin n_fail++; $display("FAIL b2b_first: got valid %b data %h expected 1 11", rx_valid, rx_data); end
        ov0 = ov_cnt;
        send_frame(8'h22, 1'b1, 16, 1'b1);
        drive_bit(1'b1, 20);
        n_tests++; if (rx_data !== 8'h22) begin n_fail++; $display("FAIL b2b_data: got %h expected 22", rx_data); end
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", rx_valid); end
        n_tests++; if (ov_cnt - ov0 !== 0) begin n_fail++; $display("FAIL b2b_overrun: got %0d pulses expected 0", ov_cnt - ov0); end
    endtask

    task automatic test_mid_frame_reset;
        int rises0;
        int fe0;
        rx_in = 1'b0;
        repeat (88) @(negedge Bclk);
        n_tests++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before: got %b expected 1", rx_busy); end
        reset_n = 1'b0;
        repeat (2) @(negedge Bclk);
        n_tests++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", rx_busy); end
        n_tests++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid: got %b expected 0", rx_valid); end
        n_tests++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL mid_reset_data: got %h expected 00", rx_data); end
        n_tests++; if (frame_err !== 1'b0 || overrun_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_flags: got %b%b expected 00", frame_err, overrun_err); end
        reset_n = 1'b1;
        rises0 = busy_rises;
        repeat (40) @(negedge Bclk);
        n_tests++; if (busy_rises - rises0 !== 0) begin n_fail++; $display("FAIL mid_low_no_start: got %0d starts expected 0", busy_rises - rises0); end
        fe0 = fe_cnt;
        drive_bit(1'b1, 20);
        send_frame(8'h5A, 1'b1, 16, 1'b0);
        drive_bit(1'b1, 20);
        n_tests++; if (rx_data !== 8'h5A) begin n_fail++; $display("FAIL mid_next_data: got %h expected 5a", rx_data); end
        n_tests++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL mid_next_valid: got %b expected 1", rx_valid); end
        n_tests++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL mid_next_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
    endtask

    initial begin
        test_reset;
        test_receive_a5;
        test_glitch;
        test_frame_error;
        test_overrun;
        test_back_to_back;
        test_mid_frame_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fsm_rx.md
FSM_RX -- requirements
Module: fsm_rx

Interface
REQ-001 Parameter: OVERSAMPLE, default 16, Bclk cycles per serial bit period; even value, minimum 4.
REQ-002 Port: Bclk  input  1  receiver clock, OVERSAMPLE times the bit rate; all logic on the rising edge.
REQ-003 Port: reset_n  input  1  reset, synchronous, active-low; sampled on the Bclk rising edge.
REQ-004 Port: rx_in  input  1  asynchronous serial line; idles high; frame is 8N1, LSB first.
REQ-005 Port: rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-006 Port: rx_data  output  8  last correctly received byte.
REQ-007 Port: rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-008 Port: rx_busy  output  1  high in every state other than IDLE.
REQ-009 Port: frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
REQ-010 Port: overrun_err  output  1  one-cycle pulse when a byte overwrites an unconsumed byte.

Function
REQ-011 rx_in SHALL pass through a 2-flop synchronizer; a third flop holds the previous synchronized value; all decisions use the synchronized value s.
REQ-012 States SHALL be IDLE, START, DATA, STOP, encoded on 2 bits.
REQ-013 IDLE -> START SHALL occur on a falling edge of s (previous 1, current 0); the tick counter clears to 0.
REQ-014 In START, DATA and STOP the tick counter SHALL increment every cycle; it SHALL wrap to 0 at each sample point.
REQ-015 START: at tick OVERSAMPLE/2-1, if s=0 -> DATA with bit_count=0; if s=1 -> IDLE (glitch rejected, no flags).
REQ-016 DATA: at tick OVERSAMPLE-1, s SHALL shift into shift_reg MSB-side ({s, shift_reg[7:1]}), giving LSB-first assembly.
REQ-017 DATA: after the 8th sample (bit_count=7), go to STOP; otherwise bit_count increments. bit_count SHALL NOT wrap within a frame.
REQ-018 STOP: at tick OVERSAMPLE-1, if s=1 then rx_data<=shift_reg, rx_valid<=1, state -> IDLE, all on the following edge.
REQ-019 STOP with s=0: frame_err SHALL pulse for 1 cycle and rx_data/rx_valid SHALL be unchanged; remain in STOP (counter halted) until s=1, then go to IDLE.
REQ-020 rx_valid SHALL clear on the cycle after rx_ack=1, unless a byte is delivered in that same cycle.
REQ-021 Byte delivered while rx_valid=1 and rx_ack=0: rx_data is overwritten, rx_valid stays 1, overrun_err pulses 1 cycle.
REQ-022 Byte delivered with rx_ack=1 in the same cycle: the new byte is loaded, rx_valid stays 1, and there is no overrun.
REQ-023 rx_ack while rx_valid=0 SHALL have no effect.
REQ-024 Latency: rx_valid SHALL rise 1 cycle after the stop sample, which occurs OVERSAMPLE/2 + 9*OVERSAMPLE cycles after the IDLE->START transition.
REQ-025 rx_busy SHALL be combinational from the state (0 only in IDLE).

Reset
REQ-026 reset_n=0 at a Bclk edge SHALL force: state=IDLE, counters=0, shift_reg=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun_err=0, rx_busy=0.
REQ-027 Synchronizer and previous-value flops SHALL reset to 0, so no start is detected until s has been 1 after reset.
REQ-028 Reset mid-frame SHALL abandon the frame without delivering data or flags.

Verification
REQ-029 OVERSAMPLE=16, rx_in sends 0xA5 (line 0,1,0,1,0,0,1,0,1,1) -> rx_data=8'hA5 and rx_valid=1 exactly 153 cycles after START entry; frame_err=0.
REQ-030 rx_in low for 5 cycles, then high -> START returns to IDLE at tick 7; rx_valid, frame_err and rx_busy return to 0/idle with no data change.
REQ-031 Frame 0x3C with stop bit driven 0 for 20 bit periods -> frame_err pulses once, rx_valid stays 0, and the FSM stays in STOP until the line rises.
REQ-032 Frames 0x11 then 0x22 with no rx_ack -> overrun_err pulses once, rx_data=8'h22, rx_valid=1; then rx_ack -> rx_valid=0 on the next cycle.
REQ-033 rx_ack asserted on the exact delivery cycle of 0x22 while 0x11 is pending -> rx_data=8'h22, rx_valid=1, overrun_err=0.
REQ-034 reset_n=0 during data bit 4 while rx_in is held low -> all outputs reset; no frame detected until rx_in goes high then low; the next 0x5A is received correctly.
